// File: rtl/rv_pkg.sv
// Shared RV32I definitions: writeback select encoding, load funct3 codes
// and the default datapath width. Used by decode, MEM/WB and writeback.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword from an aligned load
// word. Purely combinational. Unknown funct3 encodings pass the full word.
module load_formatter #(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] load_word,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] load_value
);
    import rv_pkg::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select: byte by full offset, halfword by offset bit 1 only.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = load_word[7:0];
            2'd1:    byte_lane = load_word[15:8];
            2'd2:    byte_lane = load_word[23:16];
            default: byte_lane = load_word[31:24];
        endcase
        half_lane = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    // Sign/zero extension according to load type.
    always_comb begin
        case (load_funct3)
            F3_LB:   load_value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  load_value = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   load_value = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  load_value = {{(XLEN-16){1'b0}}, half_lane};
            default: load_value = load_word;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file. Selects the writeback
// value, commits it, serves two combinational read ports with write-first
// bypass, exposes the in-flight write for forwarding and counts retirements.
module wb_regfile #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [1:0]      wb_sel,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_alu_result,
    input  logic [XLEN-1:0] wb_load_word,
    input  logic [2:0]      wb_load_funct3,
    input  logic [1:0]      wb_addr_lo,
    input  logic [XLEN-1:0] wb_pc_plus_four,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [63:0]     instret
);
    import rv_pkg::*;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] wb_value;
    logic            we;

    load_formatter #(.XLEN(XLEN)) u_load_formatter (
        .load_word   (wb_load_word),
        .load_funct3 (wb_load_funct3),
        .addr_lo     (wb_addr_lo),
        .load_value  (load_value)
    );

    // resetn gates the enable so a write presented during reset is dropped
    // and never bypassed or forwarded.
    assign we = wb_valid & wb_reg_write & (wb_rd != 5'd0)
              & (wb_sel != WB_NONE) & resetn;

    // Writeback value mux.
    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_LOAD: wb_value = load_value;
            WB_PC4:  wb_value = wb_pc_plus_four;
            default: wb_value = wb_alu_result;
        endcase
    end

    // Register array: synchronous clear, commit on we. Entry 0 stays zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wb_rd] <= wb_value;
        end
    end

    // Read ports: x0 reads zero, then write-first bypass, then the array.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (we && (wb_rd == rs1_addr)) ? wb_value : regs[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            rs2_data = (we && (wb_rd == rs2_addr)) ? wb_value : regs[rs2_addr];
        end
    end

    assign fwd_valid = we;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_value;

    // Retired-instruction counter; counts every valid WB slot and wraps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            instret <= '0;
        end else if (wb_valid) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    import rv_pkg::*;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_load_word;
    logic [2:0]  wb_load_funct3;
    logic [1:0]  wb_addr_lo;
    logic [31:0] wb_pc_plus_four;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    int checks = 0;
    int passed = 0;

    wb_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_sel          (wb_sel),
        .wb_rd           (wb_rd),
        .wb_alu_result   (wb_alu_result),
        .wb_load_word    (wb_load_word),
        .wb_load_funct3  (wb_load_funct3),
        .wb_addr_lo      (wb_addr_lo),
        .wb_pc_plus_four (wb_pc_plus_four),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .instret         (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid        = 1'b0;
        wb_reg_write    = 1'b0;
        wb_sel          = WB_NONE;
        wb_rd           = 5'd0;
        wb_alu_result   = 32'h0;
        wb_load_word    = 32'h0;
        wb_load_funct3  = F3_LW;
        wb_addr_lo      = 2'd0;
        wb_pc_plus_four = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        resetn   = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        tick();
        // a write presented while in reset must not show as in flight
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd4; wb_alu_result = 32'hCAFE0001;
        #1;
        checks++;
        if (fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid: got %b expected 0", fwd_valid);
        else passed++;
        tick();
        idle();
        resetn = 1'b1;
        #1;
        checks++;
        if (instret !== 64'd0) $display("FAIL reset_instret: got %0d expected 0", instret);
        else passed++;
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
                $display("FAIL reset_read_x%0d: got rs1=%h rs2=%h expected 0", i, rs1_data, rs2_data);
            else passed++;
        end
    endtask

    task automatic test_alu_bypass();
        idle();
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd5; wb_alu_result = 32'hDEADBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) $display("FAIL alu_bypass_rs1: got %h expected deadbeef", rs1_data);
        else passed++;
        checks++;
        if (rs2_data !== 32'hDEADBEEF) $display("FAIL alu_bypass_rs2: got %h expected deadbeef", rs2_data);
        else passed++;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'hDEADBEEF)
            $display("FAIL alu_fwd: got v=%b rd=%0d d=%h expected v=1 rd=5 d=deadbeef", fwd_valid, fwd_rd, fwd_data);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) $display("FAIL alu_stored: got %h expected deadbeef", rs1_data);
        else passed++;
        rs2_addr = 5'd6;
        #1;
        checks++;
        if (rs2_data !== 32'h0) $display("FAIL alu_other_reg: got %h expected 0", rs2_data);
        else passed++;
    endtask

    task automatic test_load_format();
        logic [2:0]  f3  [7] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LH, 3'b011};
        logic [1:0]  alo [7] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                                 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01};
        rs1_addr = 5'd10;
        for (int i = 0; i < 7; i++) begin
            idle();
            wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_LOAD;
            wb_rd = 5'd10; wb_load_word = 32'h80FF7F01;
            wb_alu_result = 32'h5555AAAA;
            wb_load_funct3 = f3[i]; wb_addr_lo = alo[i];
            #1;
            checks++;
            if (fwd_data !== exp[i] || rs1_data !== exp[i])
                $display("FAIL load_fmt_%0d: got fwd=%h rs1=%h expected %h", i, fwd_data, rs1_data, exp[i]);
            else passed++;
            tick();
        end
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h80FF7F01) $display("FAIL load_stored: got %h expected 80ff7f01", rs1_data);
        else passed++;
    endtask

    task automatic test_x0();
        idle();
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd0; wb_alu_result = 32'h12345678;
        rs2_addr = 5'd0;
        #1;
        checks++;
        if (rs2_data !== 32'h0) $display("FAIL x0_read: got %h expected 0", rs2_data);
        else passed++;
        checks++;
        if (fwd_valid !== 1'b0) $display("FAIL x0_fwd_valid: got %b expected 0", fwd_valid);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'h0) $display("FAIL x0_after: got %h expected 0", rs2_data);
        else passed++;
    endtask

    task automatic test_jal_none();
        do_reset();
        rs1_addr = 5'd1;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_PC4;
        wb_rd = 5'd1; wb_pc_plus_four = 32'h00000104; wb_alu_result = 32'h77777777;
        #1;
        checks++;
        if (fwd_data !== 32'h00000104 || rs1_data !== 32'h00000104)
            $display("FAIL jal_link: got fwd=%h rs1=%h expected 00000104", fwd_data, rs1_data);
        else passed++;
        tick();
        wb_sel = WB_NONE; wb_alu_result = 32'h0000FFFF; wb_pc_plus_four = 32'h00000999;
        #1;
        checks++;
        if (fwd_valid !== 1'b0) $display("FAIL none_fwd_valid: got %b expected 0", fwd_valid);
        else passed++;
        checks++;
        if (rs1_data !== 32'h00000104) $display("FAIL none_bypass: got %h expected 00000104", rs1_data);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h00000104) $display("FAIL none_x1: got %h expected 00000104", rs1_data);
        else passed++;
        checks++;
        if (instret !== 64'd2) $display("FAIL none_instret: got %0d expected 2", instret);
        else passed++;
        // valid without reg_write still retires but writes nothing
        wb_valid = 1'b1; wb_reg_write = 1'b0; wb_sel = WB_ALU;
        wb_rd = 5'd1; wb_alu_result = 32'hBADBAD00;
        #1;
        checks++;
        if (fwd_valid !== 1'b0 || rs1_data !== 32'h00000104)
            $display("FAIL nowrite: got v=%b rs1=%h expected v=0 rs1=00000104", fwd_valid, rs1_data);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (instret !== 64'd3 || rs1_data !== 32'h00000104)
            $display("FAIL nowrite_after: got instret=%0d rs1=%h expected 3 00000104", instret, rs1_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd3; wb_alu_result = 32'h00000011;
        #1;
        checks++;
        if (rs1_data !== 32'h11 || rs2_data !== 32'h11)
            $display("FAIL b2b_first: got rs1=%h rs2=%h expected 00000011", rs1_data, rs2_data);
        else passed++;
        tick();
        wb_alu_result = 32'h00000022;
        #1;
        checks++;
        if (rs1_data !== 32'h22 || rs2_data !== 32'h22)
            $display("FAIL b2b_second: got rs1=%h rs2=%h expected 00000022", rs1_data, rs2_data);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h22) $display("FAIL b2b_last_wins: got %h expected 00000022", rs1_data);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        idle();
        rs1_addr = 5'd7;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd7; wb_alu_result = 32'h00000055;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h55) $display("FAIL pre_reset_x7: got %h expected 00000055", rs1_data);
        else passed++;
        resetn = 1'b0;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_sel = WB_ALU;
        wb_rd = 5'd7; wb_alu_result = 32'h000000AA;
        #1;
        checks++;
        if (fwd_valid !== 1'b0) $display("FAIL midreset_fwd: got %b expected 0", fwd_valid);
        else passed++;
        tick();
        idle();
        resetn = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'h0) $display("FAIL midreset_x7: got %h expected 0", rs1_data);
        else passed++;
        checks++;
        if (instret !== 64'd0) $display("FAIL midreset_instret: got %0d expected 0", instret);
        else passed++;
    endtask

    initial begin
        idle();
        resetn   = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        test_reset();
        test_alu_bypass();
        test_load_format();
        test_x0();
        test_jal_none();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
